dac_pwm_multi: RTL and testbench
================================

// Module: dac_pwm_multi
// PURPOSE
//  Multi-channel audio DAC output stage: converts CHANNELS signed samples into 1-bit
//  pulse streams for external RC filters. Selectable edge-aligned PWM, center-aligned
//  PWM or first-order sigma-delta. Double-buffered sample input with valid/ready
//  handshake; new samples become active only at a period boundary.
//  Sits between the demodulator/audio path and the board PWM pins.
// PARAMETERS
//  CHANNELS  2   number of independent output channels (1..8)
//  DATA_W    16  signed sample width; must be >= CNT_W
//  CNT_W     10  PWM resolution; period = 2^CNT_W ticks
//  DIV       1   clk_in cycles per tick (1..65535); 1 = tick every clock
// PORTS
//  clk_in       in   1                 system clock
//  RST          in   1                 reset, synchronous, active-high
//  enable       in   1                 1 = run, 0 = outputs idle low
//  mode         in   2                 0 edge PWM, 1 center PWM, 2 sigma-delta, 3 = same as 0
//  data_in      in   CHANNELS*DATA_W   signed samples, ch0 in LSBs
//  data_valid   in   1                 sample set offered
//  data_ready   out  1                 pending buffer empty, set accepted
//  dac_out      out  CHANNELS          registered 1-bit outputs
//  period_start out  1                 1-cycle pulse on counter wrap to 0
// BEHAVIOUR
//  - Reset: dac_out=0, period_start=0, data_ready=1, counter/prescaler=0, pending
//    empty, active codes = midscale u=2^(DATA_W-1), SD accumulators=0, active mode=0.
//  - Offset binary per channel: u = data + 2^(DATA_W-1) (MSB invert), unsigned DATA_W.
//    duty = u[DATA_W-1 -: CNT_W].
//  - Prescaler counts 0..DIV-1; tick when it reaches DIV-1. Counter cnt (CNT_W bits)
//    increments on tick, wraps 2^CNT_W-1 -> 0; period_start asserted the cycle
//    after the wrap tick.
//  - Handshake: transfer when data_valid & data_ready; whole vector latched into
//    pending, data_ready drops next cycle. On wrap tick: if pending full, copy to
//    active and clear pending (ready=1 next cycle); mode input sampled into active
//    mode on same wrap tick. Transfer and commit in the same cycle: commit the old
//    pending; new set is not accepted (ready was 0). No sample ever dropped/overwritten.
//  - Edge PWM: dac_out = (cnt < duty). duty=0 -> constant 0; max = 2^CNT_W-1 high
//    ticks per period.
//  - Center PWM: fold = cnt[CNT_W-1] ? ~cnt[CNT_W-2:0] : cnt[CNT_W-2:0];
//    dac_out = (fold < duty[CNT_W-1:1]); high window symmetric about the wrap.
//  - Sigma-delta: per channel, on each tick {c,acc} = acc + u (DATA_W+1 bits);
//    dac_out = c. Density = u/2^DATA_W; uses full DATA_W, not duty.
//  - Output latency: dac_out reflects the compare of the cnt/acc value one cycle
//    earlier (single output register). Held between ticks.
//  - Active-mode change at wrap clears all accumulators.
//  - enable=0: prescaler, cnt, accumulators held at 0, dac_out=0, period_start=0;
//    handshake still operates (pending fills, no commit). enable rising: period
//    starts at cnt=0 with pending committed on first wrap.
//  - RST mid-period: immediate return to reset state next cycle; pending discarded.
// TESTING  (CHANNELS=2, DATA_W=8, CNT_W=4, DIV=1 unless stated; period 16 clks)
//  1 Reset: RST=1 3 clks, enable=1 -> dac_out=00, data_ready=1, period_start=0;
//    after release with no writes, mode 0 -> both channels 8 high/16 (midscale).
//  2 Edge PWM: write ch0=-128, ch1=0x40 -> from first wrap after write: ch0 always 0,
//    ch1 high 12 of 16 clks, high on cnt 0..11 (+1 clk latency).
//  3 Buffering: two valid sets 3 clks apart mid-period -> first accepted, data_ready=0
//    until the wrap, second accepted after; active changes only at wraps.
//  4 Sigma-delta: mode=2, ch0=-64 (u=64) -> exactly 1 high per 4 clks steady state;
//    ch1=127 (u=255) -> 255 highs per 256 clks.
//  5 Center PWM: mode=1, ch0=0 (duty 8) -> high on cnt 0..3 and 12..15, low 4..11.
//  6 DIV=3: ch1=0x40 -> period 48 clks, 36 high; enable=0 mid-period -> dac_out=0
//    next clk; RST mid-period with pending full -> data_ready=1, outputs 0.

Source files
------------

// File: rtl/dac_pwm_multi.sv
// -----------------------------------------------------------------------------
// dac_pwm_multi
//   Multi-channel audio DAC output stage. Each channel turns a signed sample
//   into a 1-bit pulse stream for an external RC filter, using edge-aligned
//   PWM, center-aligned PWM or first-order sigma-delta modulation.
//   Samples arrive through a double buffer (pending -> active); a new set
//   and a new mode only take effect at a period boundary (counter wrap).
//
// Ports
//   clk_in        system clock
//   RST           synchronous, active-high reset
//   enable        1 = run, 0 = outputs held low, counters held at 0
//   mode          0 edge PWM, 1 center PWM, 2 sigma-delta, 3 edge PWM
//   data_in       CHANNELS signed samples, channel 0 in the LSBs
//   data_valid    sample set offered
//   data_ready    pending buffer empty (set will be accepted)
//   dac_out       registered 1-bit output per channel
//   period_start  one-cycle pulse in the cycle after the counter wraps
//
// Handshake: a set transfers on any clock edge where data_valid and
// data_ready are both high. data_ready is the inverse of the pending-full
// flag, so it drops the cycle after a transfer and rises again the cycle
// after the pending set is committed at a wrap tick. A held data_valid with
// data_ready low simply waits; nothing is ever overwritten or dropped.
// -----------------------------------------------------------------------------
module dac_pwm_multi #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 10,
    parameter int DIV      = 1
) (
    input  logic                       clk_in,
    input  logic                       RST,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic [CHANNELS-1:0]        dac_out,
    output logic                       period_start
);

    localparam int                PRE_W    = 16;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
    // Offset-binary midscale; also the MSB mask used for signed->unsigned.
    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_EDGE   = 2'd0,
        MODE_CENTER = 2'd1,
        MODE_SD     = 2'd2
    } mode_t;

    logic [PRE_W-1:0]                 r_presc;
    logic [CNT_W-1:0]                 r_cnt;
    logic                             r_pend_full;
    logic [CHANNELS-1:0][DATA_W-1:0]  r_pend_u;
    logic [CHANNELS-1:0][DATA_W-1:0]  r_act_u;
    logic [CHANNELS-1:0][DATA_W-1:0]  r_acc;
    mode_t                            r_mode;
    logic [CHANNELS-1:0]              r_dac;
    logic                             r_ps;

    logic                             w_tick;
    logic                             w_wrap;
    mode_t                            w_mode_in;
    logic                             w_mode_chg;
    logic [CNT_W-2:0]                 w_fold;
    logic [CHANNELS-1:0][DATA_W-1:0]  w_in_u;
    logic [CHANNELS-1:0][DATA_W:0]    w_sum;
    logic [CHANNELS-1:0]              w_next_dac;

    assign w_tick = enable && (r_presc == PRE_LAST);
    assign w_wrap = w_tick && (r_cnt == {CNT_W{1'b1}});

    // Mode 3 behaves as edge PWM, so it is folded to MODE_EDGE here; a
    // switch between 0 and 3 is therefore not a mode change.
    always_comb begin
        case (mode)
            2'd1:    w_mode_in = MODE_CENTER;
            2'd2:    w_mode_in = MODE_SD;
            default: w_mode_in = MODE_EDGE;
        endcase
    end

    assign w_mode_chg = (w_mode_in != r_mode);

    // Triangle fold of the counter: rises over the first half of the period,
    // falls over the second, so the high window straddles the wrap.
    assign w_fold = r_cnt[CNT_W-1] ? ~r_cnt[CNT_W-2:0] : r_cnt[CNT_W-2:0];

    always_comb begin
        w_in_u     = '0;
        w_sum      = '0;
        w_next_dac = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_in_u[i] = data_in[i*DATA_W +: DATA_W] ^ MID;
            w_sum[i]  = {1'b0, r_acc[i]} + {1'b0, r_act_u[i]};
            case (r_mode)
                MODE_CENTER: w_next_dac[i] = (w_fold < r_act_u[i][DATA_W-1 -: (CNT_W-1)]);
                // Sigma-delta output is the carry, updated on ticks only.
                MODE_SD:     w_next_dac[i] = w_tick ? w_sum[i][DATA_W] : r_dac[i];
                default:     w_next_dac[i] = (r_cnt < r_act_u[i][DATA_W-1 -: CNT_W]);
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_presc     <= '0;
            r_cnt       <= '0;
            r_pend_full <= 1'b0;
            r_pend_u    <= '0;
            r_act_u     <= {CHANNELS{MID}};
            r_acc       <= '0;
            r_mode      <= MODE_EDGE;
            r_dac       <= '0;
            r_ps        <= 1'b0;
        end else begin
            // Transfer needs an empty buffer and commit needs a full one, so
            // the two never coincide; a set offered during a commit waits.
            if (data_valid && !r_pend_full) begin
                r_pend_u    <= w_in_u;
                r_pend_full <= 1'b1;
            end
            if (w_wrap && r_pend_full) begin
                r_act_u     <= r_pend_u;
                r_pend_full <= 1'b0;
            end

            if (!enable) begin
                r_presc <= '0;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_dac   <= '0;
                r_ps    <= 1'b0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_ps  <= w_wrap;
                r_dac <= w_next_dac;

                if (w_wrap && w_mode_chg) begin
                    r_acc <= '0;
                end else if (w_tick && (r_mode == MODE_SD)) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_acc[i] <= w_sum[i][DATA_W-1:0];
                    end
                end

                if (w_wrap) begin
                    r_mode <= w_mode_in;
                end
            end
        end
    end

    assign data_ready   = ~r_pend_full;
    assign dac_out      = r_dac;
    assign period_start = r_ps;

endmodule

// File: tb/tb_dac_pwm_multi.sv
module tb_dac_pwm_multi;

    localparam int EW = 40;   // {window index[7:0], ch1 pattern[15:0], ch0 pattern[15:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: DIV=1
    logic        rst1, en1, vld1, rdy1, ps1;
    logic [1:0]  mode1;
    logic [15:0] din1;
    logic [1:0]  dac1;

    // DUT 2: DIV=3
    logic        rst2, en2, vld2, rdy2, ps2;
    logic [1:0]  mode2;
    logic [15:0] din2;
    logic [1:0]  dac2;

    dac_pwm_multi #(.CHANNELS(2), .DATA_W(8), .CNT_W(4), .DIV(1)) dut1 (
        .clk_in(clk), .RST(rst1), .enable(en1), .mode(mode1), .data_in(din1),
        .data_valid(vld1), .data_ready(rdy1), .dac_out(dac1), .period_start(ps1)
    );

    dac_pwm_multi #(.CHANNELS(2), .DATA_W(8), .CNT_W(4), .DIV(3)) dut2 (
        .clk_in(clk), .RST(rst2), .enable(en2), .mode(mode2), .data_in(din2),
        .data_valid(vld2), .data_ready(rdy2), .dac_out(dac2), .period_start(ps2)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            mon_idx = 0;
    logic [15:0]   pat0 = '0;
    logic [15:0]   pat1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int idx, input logic [15:0] p1, input logic [15:0] p0);
        return {idx[7:0], p1, p0};
    endfunction

    // Monitor: bit j of each pattern is the output for counter value j of
    // the period that ends at the period_start sample.
    always @(negedge clk) begin
        if (rst1 || !en1) begin
            mon_idx = 0;
            pat0    = '0;
            pat1    = '0;
        end else begin
            pat0 = {dac1[0], pat0[15:1]};
            pat1 = {dac1[1], pat1[15:1]};
            if (ps1) begin
                mon_idx++;
                while (exp_q.size() > 0 && exp_q[0][39:32] < 8'(mon_idx)) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL window_missed: window %0d not seen, now at %0d", mon_e[39:32], mon_idx);
                end
                if (exp_q.size() > 0 && exp_q[0][39:32] == 8'(mon_idx)) begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("win%0d_ch0", mon_idx), {16'h0, pat0}, {16'h0, mon_e[15:0]});
                    check($sformatf("win%0d_ch1", mon_idx), {16'h0, pat1}, {16'h0, mon_e[31:16]});
                end
            end
        end
    end

    // Leaves the caller in the cycle after period_start (counter = 1).
    task automatic wait_ps1(output int idx);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_ps1: period_start got 0 expected 1 within 200 clks");
        end
        @(posedge clk); #1;
        idx = mon_idx;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending windows expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic offer1(input logic [15:0] d, output int stall);
        logic r;
        bit   done = 0;
        stall = 0;
        vld1  = 1'b1;
        din1  = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = rdy1;
            @(posedge clk); #1;
            if (r) begin
                done = 1;
                break;
            end
            stall++;
        end
        vld1 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL offer1: accepted got 0 expected 1 within 300 clks");
        end
    endtask

    task automatic offer2(input logic [15:0] d);
        logic r;
        bit   done = 0;
        vld2 = 1'b1;
        din2 = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = rdy2;
            @(posedge clk); #1;
            if (r) begin
                done = 1;
                break;
            end
        end
        vld2 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL offer2: accepted got 0 expected 1 within 300 clks");
        end
    endtask

    task automatic wait_ps2();
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ps2) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_ps2: period_start got 0 expected 1 within 300 clks");
        end
    endtask

    // Called at the period_start sample; counts one full period of DUT 2.
    task automatic measure2(output int n, output int c0, output int c1);
        n = 0; c0 = 0; c1 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            c0 += int'(dac2[0]);
            c1 += int'(dac2[1]);
            if (ps2) break;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, st, n, c0, c1;

        rst1 = 1'b1; en1 = 1'b1; mode1 = 2'd0; din1 = '0; vld1 = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 2'd0; din2 = '0; vld2 = 1'b0;

        // Reset state, then midscale default in edge mode.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dac", {30'h0, dac1}, 32'h0);
        check("rst_ready", {31'h0, rdy1}, 32'h1);
        check("rst_ps", {31'h0, ps1}, 32'h0);
        exp_q.push_back(mk(1, 16'h00FF, 16'h00FF));
        exp_q.push_back(mk(2, 16'h00FF, 16'h00FF));
        @(posedge clk); #1;
        rst1 = 1'b0;

        // Edge PWM: ch0=-128 (never high), ch1=0x40 (high on cnt 0..11).
        drain();
        wait_ps1(k);
        exp_q.push_back(mk(k + 1, 16'h00FF, 16'h00FF));
        exp_q.push_back(mk(k + 2, 16'h0FFF, 16'h0000));
        offer1({8'h40, 8'h80}, st);
        check("ready_drop", {31'h0, rdy1}, 32'h0);

        // Buffering: A accepted at cnt 1, B offered at cnt 4 waits for the wrap.
        drain();
        wait_ps1(k);
        exp_q.push_back(mk(k + 1, 16'h0FFF, 16'h0000));
        exp_q.push_back(mk(k + 2, 16'h000F, 16'h0FFF));
        exp_q.push_back(mk(k + 3, 16'h7FFF, 16'h00FF));
        offer1({8'hC0, 8'h40}, st);
        check("bufA_stall", st, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("buf_ready_low", {31'h0, rdy1}, 32'h0);
        offer1({8'h70, 8'h00}, st);
        check("bufB_stall", st, 12);

        // Sigma-delta: u=64 -> every 4th tick; u=255 -> one low per 256 ticks.
        drain();
        wait_ps1(k);
        mode1 = 2'd2;
        exp_q.push_back(mk(k + 1, 16'h7FFF, 16'h00FF));
        exp_q.push_back(mk(k + 2, 16'hFFFE, 16'h8888));
        for (int w = 3; w <= 17; w++) exp_q.push_back(mk(k + w, 16'hFFFF, 16'h8888));
        exp_q.push_back(mk(k + 18, 16'hFFFE, 16'h8888));
        offer1({8'h7F, 8'hC0}, st);

        // Center PWM: duty 8 -> cnt 0..3,12..15; duty 12 -> cnt 0..5,10..15.
        drain();
        wait_ps1(k);
        mode1 = 2'd1;
        exp_q.push_back(mk(k + 2, 16'hFC3F, 16'hF00F));
        exp_q.push_back(mk(k + 3, 16'hFC3F, 16'hF00F));
        offer1({8'h40, 8'h00}, st);

        // Mode 3 as edge PWM, full-scale and zero codes.
        drain();
        wait_ps1(k);
        mode1 = 2'd3;
        exp_q.push_back(mk(k + 1, 16'hFC3F, 16'hF00F));
        exp_q.push_back(mk(k + 2, 16'h0000, 16'h7FFF));
        offer1({8'h80, 8'h7F}, st);
        drain();

        // DIV=3 instance.
        @(posedge clk); #1;
        rst2 = 1'b0;
        en2  = 1'b1;
        offer2({8'h40, 8'h00});
        wait_ps2();
        measure2(n, c0, c1);
        check("div3_period", n, 48);
        check("div3_ch0_high", c0, 24);
        check("div3_ch1_high", c1, 36);
        repeat (6) begin @(posedge clk); #1; end
        check("div3_pre_dis_high", {31'h0, dac2[1]}, 32'h1);
        en2 = 1'b0;
        @(posedge clk); #1;
        check("dis_dac", {30'h0, dac2}, 32'h0);
        check("dis_ps", {31'h0, ps2}, 32'h0);
        offer2({8'hC0, 8'hC0});
        check("dis_pend_full", {31'h0, rdy2}, 32'h0);
        en2 = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        rst2 = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", {31'h0, rdy2}, 32'h1);
        check("rst_mid_dac", {30'h0, dac2}, 32'h0);
        rst2 = 1'b0;
        wait_ps2();
        measure2(n, c0, c1);
        check("rst_mid_period", n, 48);
        check("rst_mid_ch0", c0, 24);
        check("rst_mid_ch1", c1, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
